// File: rtl/alien_fleet.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alien_fleet : alien grid state, zig-zag movement, laser hits, rendering  |
// | Optional: ALIEN_FLEET_SPEEDUP_EN doubles the step when few aliens remain |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module alien_fleet #(
  parameter int         COLS      = 8,
  parameter int         ROWS      = 4,
  parameter int         ALIEN_W   = 24,
  parameter int         ALIEN_H   = 16,
  parameter int         SPACING_X = 32,
  parameter int         SPACING_Y = 32,
  parameter int         STEP_X    = 8,
  parameter int         STEP_Y    = 16,
  parameter int         START_X   = 32,
  parameter int         START_Y   = 32,
  parameter int         X_MAX     = 639,
  parameter int         X_MIN     = 0,
  parameter int         LAND_Y    = 400,
  parameter logic [2:0] COLOR     = 3'b010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       step,
  input  logic [9:0] hPos,
  input  logic [9:0] vPos,
  input  logic [9:0] xLaser,
  input  logic [9:0] yLaser,
  input  logic       laserActive,
  output logic       killingAlien,
  output logic [2:0] color,
  output logic [5:0] aliveCount,
  output logic       fleetCleared,
  output logic       fleetLanded
);

  localparam int FW    = (COLS - 1) * SPACING_X + ALIEN_W;
  localparam int FH    = (ROWS - 1) * SPACING_Y + ALIEN_H;
  localparam int N     = ROWS * COLS;
  localparam int SX_SH = $clog2(SPACING_X);
  localparam int SY_SH = $clog2(SPACING_Y);
  localparam int IW    = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_RIGHT   = 2'd0,
    S_LEFT    = 2'd1,
    S_LANDED  = 2'd2,
    S_CLEARED = 2'd3
  } state_t;

  state_t         state, state_next;
  logic [9:0]     fleet_x, fleet_y, x_next, y_next;
  logic [N-1:0]   alive, alive_next;
  logic [5:0]     count_next;
  logic [IW:0]    laser_loc, pixel_loc;
  logic           laser_hit, pixel_hit, descend;
  int             step_x;

  // Returns {inside a sprite rectangle, cell index}; the alive bit is applied by the caller.
  function automatic logic [IW:0] locate(input logic [9:0] x, input logic [9:0] y,
                                         input logic [9:0] fx, input logic [9:0] fy);
    int          dx, dy;
    logic [IW:0] res;
    dx  = int'(x) - int'(fx);
    dy  = int'(y) - int'(fy);
    res = '0;
    if (dx >= 0 && dy >= 0 && dx < FW && dy < FH &&
        (dx & (SPACING_X - 1)) < ALIEN_W && (dy & (SPACING_Y - 1)) < ALIEN_H)
      res = {1'b1, IW'((dy >> SY_SH) * COLS + (dx >> SX_SH))};
    return res;
  endfunction

  assign laser_loc = locate(xLaser, yLaser, fleet_x, fleet_y);
  assign pixel_loc = locate(hPos, vPos, fleet_x, fleet_y);
  assign laser_hit = laserActive && laser_loc[IW] && alive[laser_loc[IW-1:0]];
  assign pixel_hit = pixel_loc[IW] && alive[pixel_loc[IW-1:0]];

  always_comb begin
`ifdef ALIEN_FLEET_SPEEDUP_EN
    step_x = (int'(aliveCount) * 4 <= N) ? 2 * STEP_X : STEP_X;
`else
    step_x = STEP_X;
`endif
    state_next = state;
    x_next     = fleet_x;
    y_next     = fleet_y;
    alive_next = alive;
    count_next = aliveCount;
    descend    = 1'b0;

    if (laser_hit) begin
      alive_next[laser_loc[IW-1:0]] = 1'b0;
      count_next                    = aliveCount - 6'd1;
    end

    if (step) begin
      case (state)
        S_RIGHT: begin
          if (int'(fleet_x) + FW + step_x > X_MAX) begin
            y_next     = 10'(int'(fleet_y) + STEP_Y);
            state_next = S_LEFT;
            descend    = 1'b1;
          end else begin
            x_next = 10'(int'(fleet_x) + step_x);
          end
        end
        S_LEFT: begin
          if (int'(fleet_x) < X_MIN + step_x) begin
            y_next     = 10'(int'(fleet_y) + STEP_Y);
            state_next = S_RIGHT;
            descend    = 1'b1;
          end else begin
            x_next = 10'(int'(fleet_x) - step_x);
          end
        end
        default: ;
      endcase
    end

    if (descend && int'(y_next) + FH >= LAND_Y) state_next = S_LANDED;
    // Clearing wins over landing on the same edge.
    if (count_next == 6'd0) state_next = S_CLEARED;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_RIGHT;
      fleet_x      <= 10'(START_X);
      fleet_y      <= 10'(START_Y);
      alive        <= '1;
      aliveCount   <= 6'(N);
      killingAlien <= 1'b0;
      color        <= 3'b000;
      fleetCleared <= 1'b0;
      fleetLanded  <= 1'b0;
    end else begin
      state        <= state_next;
      fleet_x      <= x_next;
      fleet_y      <= y_next;
      alive        <= alive_next;
      aliveCount   <= count_next;
      killingAlien <= laser_hit;
      fleetCleared <= (state_next == S_CLEARED);
      fleetLanded  <= (state_next == S_LANDED);
      if (enable) color <= pixel_hit ? COLOR : 3'b000;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alien_fleet.sv
`default_nettype none
// Testbench for alien_fleet: vector table, directed corner sequences and a
// randomized run checked against a geometric reference model.
module tb_alien_fleet;

  localparam int COLS = 8, ROWS = 4, AW = 24, AH = 16, SX = 32, SY = 32;
  localparam int STEP = 8, SDY = 16, FW = 248, FH = 112;
  localparam int XMAX = 639, XMIN = 0, LANDY = 400, N = 32;
  localparam int M_RIGHT = 0, M_LEFT = 1, M_LANDED = 2, M_CLEARED = 3;

  logic       clk = 1'b0, reset = 1'b1, enable = 1'b0, step = 1'b0, laserActive = 1'b0;
  logic [9:0] hPos = '0, vPos = '0, xLaser = '0, yLaser = '0;
  logic       killingAlien, fleetCleared, fleetLanded;
  logic [2:0] color;
  logic [5:0] aliveCount;

  alien_fleet dut (
    .clk(clk), .reset(reset), .enable(enable), .step(step),
    .hPos(hPos), .vPos(vPos), .xLaser(xLaser), .yLaser(yLaser),
    .laserActive(laserActive), .killingAlien(killingAlien), .color(color),
    .aliveCount(aliveCount), .fleetCleared(fleetCleared), .fleetLanded(fleetLanded)
  );

  always #5 clk = ~clk;

  int         checks = 0, failures = 0;
  int         mx, my, mcount, mstate;
  bit         malive[N];
  bit         mkill;
  logic [2:0] mcolor;
  bit         auto_chk = 1'b0;

  typedef struct {
    int h;
    int v;
    int exp;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Which living alien (if any) covers the point, by scanning every sprite rectangle.
  function automatic int model_cell(input int x, input int y);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        int left, top;
        left = mx + c * SX;
        top  = my + r * SY;
        if (malive[r*COLS+c] && x >= left && x < left + AW && y >= top && y < top + AH)
          return r * COLS + c;
      end
    return -1;
  endfunction

  task automatic model_edge();
    int li, pi, s;
    bit desc;
    if (reset) begin
      mx = 32; my = 32; mcount = N; mstate = M_RIGHT; mkill = 0; mcolor = 3'b000;
      for (int i = 0; i < N; i++) malive[i] = 1'b1;
      return;
    end
    li = laserActive ? model_cell(int'(xLaser), int'(yLaser)) : -1;
    pi = model_cell(int'(hPos), int'(vPos));
    s  = STEP;
`ifdef ALIEN_FLEET_SPEEDUP_EN
    if (mcount * 4 <= N) s = 2 * STEP;
`endif
    mkill = (li >= 0);
    if (enable) mcolor = (pi >= 0) ? 3'b010 : 3'b000;
    desc = 1'b0;
    if (step && mstate == M_RIGHT) begin
      if (mx + FW + s > XMAX) begin my += SDY; mstate = M_LEFT; desc = 1'b1; end
      else mx += s;
    end else if (step && mstate == M_LEFT) begin
      if (mx < XMIN + s) begin my += SDY; mstate = M_RIGHT; desc = 1'b1; end
      else mx -= s;
    end
    if (desc && my + FH >= LANDY) mstate = M_LANDED;
    if (li >= 0) begin
      malive[li] = 1'b0;
      mcount--;
      if (mcount == 0) mstate = M_CLEARED;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    if (auto_chk) begin
      chk("rnd_kill", killingAlien, mkill);
      chk("rnd_color", color, mcolor);
      chk("rnd_count", aliveCount, mcount);
      chk("rnd_cleared", fleetCleared, int'(mstate == M_CLEARED));
      chk("rnd_landed", fleetLanded, int'(mstate == M_LANDED));
      chk("rnd_fleet_x", int'(dut.fleet_x), mx);
      chk("rnd_fleet_y", int'(dut.fleet_y), my);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; step = 1'b0; laserActive = 1'b0; enable = 1'b0;
    cycle();
    reset = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1; cycle();
    step = 1'b0; cycle();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_x"}, int'(dut.fleet_x), 32);
    chk({tag, "_y"}, int'(dut.fleet_y), 32);
    chk({tag, "_count"}, aliveCount, 32);
    chk({tag, "_kill"}, killingAlien, 0);
    chk({tag, "_color"}, color, 0);
    chk({tag, "_cleared"}, fleetCleared, 0);
    chk({tag, "_landed"}, fleetLanded, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses, n, sx;

    tbl[0]  = '{32, 32, 2};   tbl[1]  = '{56, 32, 0};   tbl[2]  = '{32, 48, 0};
    tbl[3]  = '{55, 47, 2};   tbl[4]  = '{279, 32, 2};  tbl[5]  = '{280, 32, 0};
    tbl[6]  = '{31, 32, 0};   tbl[7]  = '{32, 31, 0};   tbl[8]  = '{279, 143, 2};
    tbl[9]  = '{279, 144, 0}; tbl[10] = '{100, 130, 2}; tbl[11] = '{120, 130, 0};
    tbl[12] = '{64, 64, 2};   tbl[13] = '{287, 40, 0};

    do_reset();
    check_reset_state("reset");

    enable = 1'b1;
    for (int i = 0; i < 14; i++) begin
      hPos = 10'(tbl[i].h);
      vPos = 10'(tbl[i].v);
      cycle();
      chk($sformatf("render_vec%0d", i), color, tbl[i].exp);
    end
    enable = 1'b0;
    hPos = 10'd32; vPos = 10'd32;
    cycle();
    chk("render_hold", color, 0);

    // Single hit held for three cycles.
    do_reset();
    laserActive = 1'b1; xLaser = 10'd101; yLaser = 10'd37;
    pulses = 0;
    repeat (3) begin cycle(); pulses += int'(killingAlien); end
    laserActive = 1'b0;
    cycle(); pulses += int'(killingAlien);
    chk("hit_pulses", pulses, 1);
    chk("hit_count", aliveCount, 31);
    enable = 1'b1; hPos = 10'd96; vPos = 10'd32;
    cycle();
    chk("hit_dead_pixel", color, 0);
    hPos = 10'd64;
    cycle();
    chk("hit_neighbour_pixel", color, 2);
    enable = 1'b0;

    // Zig-zag across the right edge.
    do_reset();
    repeat (44) pulse_step();
    chk("zig44_x", int'(dut.fleet_x), 384);
    chk("zig44_y", int'(dut.fleet_y), 32);
    pulse_step();
    chk("zig45_x", int'(dut.fleet_x), 384);
    chk("zig45_y", int'(dut.fleet_y), 48);
    pulse_step();
    chk("zig46_x", int'(dut.fleet_x), 376);
    chk("zig46_y", int'(dut.fleet_y), 48);
    chk("zig46_landed", fleetLanded, 0);

    // Hit and step together: hit uses the pre-step position.
    do_reset();
    laserActive = 1'b1; xLaser = 10'd32; yLaser = 10'd32; step = 1'b1;
    cycle();
    laserActive = 1'b0; step = 1'b0;
    chk("simul_kill", killingAlien, 1);
    chk("simul_count", aliveCount, 31);
    chk("simul_x", int'(dut.fleet_x), 40);
    enable = 1'b1; hPos = 10'd40; vPos = 10'd32;
    cycle();
    chk("simul_dead_pixel", color, 0);
    hPos = 10'd72;
    cycle();
    chk("simul_live_pixel", color, 2);
    enable = 1'b0;

    // Kill every alien.
    do_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        laserActive = 1'b1;
        xLaser = 10'(32 + c * SX + 5);
        yLaser = 10'(32 + r * SY + 5);
        cycle();
        laserActive = 1'b0;
        chk($sformatf("kill_r%0dc%0d", r, c), killingAlien, 1);
        chk($sformatf("kill_cleared_r%0dc%0d", r, c), fleetCleared, int'(r == ROWS-1 && c == COLS-1));
      end
    chk("kill_count", aliveCount, 0);
    repeat (3) pulse_step();
    chk("cleared_x", int'(dut.fleet_x), 32);
    chk("cleared_y", int'(dut.fleet_y), 32);
    chk("cleared_hold", fleetCleared, 1);
    chk("cleared_not_landed", fleetLanded, 0);

    // Landing.
    do_reset();
    n = 0;
    while (!fleetLanded && n < 3000) begin pulse_step(); n++; end
    chk("land_reached", fleetLanded, 1);
    chk("land_y", int'(dut.fleet_y), 288);
    chk("land_x", int'(dut.fleet_x), mx);
    sx = int'(dut.fleet_x);
    repeat (3) pulse_step();
    chk("land_hold_x", int'(dut.fleet_x), sx);
    chk("land_hold_y", int'(dut.fleet_y), 288);
    chk("land_hold", fleetLanded, 1);
    chk("land_not_cleared", fleetCleared, 0);
    do_reset();
    check_reset_state("relreset");

    // Randomized run against the model, with occasional resets.
    do_reset();
    auto_chk = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 299) == 0);
      step        = ($urandom_range(0, 3) == 0);
      enable      = ($urandom_range(0, 1) == 1);
      laserActive = ($urandom_range(0, 5) == 0);
      xLaser      = 10'(mx + int'($urandom_range(0, FW + 16)) - 8);
      yLaser      = 10'(my + int'($urandom_range(0, FH + 16)) - 8);
      hPos        = 10'(mx + int'($urandom_range(0, FW + 16)) - 8);
      vPos        = 10'(my + int'($urandom_range(0, FH + 16)) - 8);
      cycle();
    end
    auto_chk = 1'b0;
    reset = 1'b0; step = 1'b0; laserActive = 1'b0; enable = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
